// File: rtl/cgra_clk_ctrl_pkg.sv
// Shared types and constants for the CGRA clock-gating controller.
//   cgra_clk_state_e : FSM state encoding (OFF/WAKE/ON; 2'b11 is illegal)
//   STATS_W          : width of the gated-off cycle statistics counter
//   cnt_width()      : counter width for a cycle-count parameter, min 1 bit
package cgra_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    CLK_OFF  = 2'b00,
    CLK_WAKE = 2'b01,
    CLK_ON   = 2'b10
  } cgra_clk_state_e;

  localparam int unsigned STATS_W = 32;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cgra_clock_gate.sv
// Glitch-free clock gate cell for the CGRA clock.
//   clk_i     : free-running source clock
//   en_i      : functional enable (registered in the clk_i domain)
//   test_en_i : scan/test override, forces the gate open
//   clk_o     : gated clock
// The enable is captured by a latch that is transparent only while clk_i is
// low, so it cannot change during the high phase and clk_o cannot glitch.
module cgra_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latched;

  always_latch begin
    if (!clk_i) begin
      en_latched = en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & en_latched;

endmodule

// File: rtl/cgra_clk_gate_ctrl.sv
// Clock-gating controller for the CGRA clock domain (always-on domain).
// Wakes the CGRA clock on requests or activity, grants requesters once the
// clock has settled, gates it off after IDLE_CYCLES idle cycles, and counts
// cycles spent gated off.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   test_en_i     : forces the gate cell open (FSM unaffected)
//   force_on_i    : software keep-alive (activity)
//   req_i         : access request, held until granted
//   busy_i        : CGRA executing (activity)
//   gnt_o         : request granted, clock running and settled
//   clk_en_o      : registered enable to the gate cell
//   cgra_clk_o    : gated CGRA clock
//   state_o       : current FSM state
//   clr_stats_i   : synchronous clear of off_cycles_o
//   off_cycles_o  : saturating count of cycles in OFF
module cgra_clk_gate_ctrl
  import cgra_clk_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               test_en_i,
  input  logic               force_on_i,
  input  logic               req_i,
  input  logic               busy_i,
  output logic               gnt_o,
  output logic               clk_en_o,
  output logic               cgra_clk_o,
  output logic [1:0]         state_o,
  input  logic               clr_stats_i,
  output logic [STATS_W-1:0] off_cycles_o
);

  localparam int unsigned IDLE_W = cnt_width(IDLE_CYCLES);
  localparam int unsigned WAKE_W = cnt_width(WAKE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  cgra_clk_state_e    state_q, state_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [STATS_W-1:0] off_cycles_q, off_cycles_d;
  logic               clk_en_q;
  logic               activity;

  assign activity = req_i | busy_i | force_on_i;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      CLK_OFF: begin
        if (activity) begin
          state_d    = CLK_WAKE;
          wake_cnt_d = '0;
        end
      end
      CLK_WAKE: begin
        // Settling always runs to completion regardless of activity.
        wake_cnt_d = wake_cnt_q + 1'b1;
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = CLK_ON;
          idle_cnt_d = '0;
        end
      end
      CLK_ON: begin
        if (activity) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_q == IDLE_LAST) begin
            state_d = CLK_OFF;
          end
        end
      end
      default: state_d = CLK_OFF;
    endcase
  end

  // Clear has priority over the saturating increment.
  always_comb begin
    off_cycles_d = off_cycles_q;
    if (clr_stats_i) begin
      off_cycles_d = '0;
    end else if ((state_q == CLK_OFF) && (off_cycles_q != '1)) begin
      off_cycles_d = off_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= CLK_OFF;
      wake_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      off_cycles_q <= '0;
      clk_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_cnt_q   <= wake_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      off_cycles_q <= off_cycles_d;
      // Taken from the next state so the enable is already high in the
      // first WAKE cycle.
      clk_en_q     <= (state_d == CLK_WAKE) || (state_d == CLK_ON);
    end
  end

  assign gnt_o        = req_i & (state_q == CLK_ON);
  assign clk_en_o     = clk_en_q;
  assign state_o      = state_q;
  assign off_cycles_o = off_cycles_q;

  cgra_clock_gate u_clock_gate (
    .clk_i     (clk_i),
    .en_i      (clk_en_q),
    .test_en_i (test_en_i),
    .clk_o     (cgra_clk_o)
  );

endmodule

// File: doc/cgra_clk_gate_ctrl.md
# cgra_clk_gate_ctrl

Clock-gating controller for the CGRA clock domain. It sequences the enable of the CGRA clock-gate cell: it wakes the clock on bus/host requests or CGRA activity, grants requesters only once the clock has settled, and shuts the clock off after a programmable number of consecutive idle cycles. It sits between the system bus adapter / CGRA top and the gate cell, in the always-on clock domain, and also counts gated-off cycles for power monitoring.

## Interface
- `IDLE_CYCLES`, default 16: number of consecutive idle cycles in ON before gating off; range 1..65535.
- `WAKE_CYCLES`, default 2: number of settle cycles in WAKE before grants are allowed; range 1..255.
- `clk_i` input 1: free-running clock, the only clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `test_en_i` input 1: scan/test mode; forces the gate cell open; controller state is unaffected.
- `force_on_i` input 1: software keep-alive; counts as activity.
- `req_i` input 1: access request to the CGRA, held until granted.
- `busy_i` input 1: CGRA is executing; counts as activity.
- `gnt_o` output 1: grant; the CGRA clock is running and settled.
- `clk_en_o` output 1: registered enable to the gate cell.
- `cgra_clk_o` output 1: gated CGRA clock.
- `state_o` output 2: current state, for debug/status.
- `clr_stats_i` input 1: synchronous clear of `off_cycles_o`.
- `off_cycles_o` output 32: saturating count of cycles spent in OFF.

## Operation
- Activity is `req_i | busy_i | force_on_i`.
- States are OFF=2'b00, WAKE=2'b01, ON=2'b10. Code 2'b11 is illegal and recovers to OFF on the next edge.
- **OFF**
  - Activity moves the block to WAKE and loads the wake counter with 0.
  - Otherwise it stays in OFF.
- **WAKE**
  - The wake counter increments each cycle.
  - When the counter equals WAKE_CYCLES-1, the next state is ON and the idle counter is cleared.
  - WAKE always completes, even if activity drops.
- **ON**
  - Activity clears the idle counter.
  - With no activity, the idle counter increments.
  - If there is no activity and the idle counter equals IDLE_CYCLES-1, the next state is OFF.
- `clk_en_o` is registered and equals 1 in WAKE and ON, 0 in OFF. It is driven from the next-state value, so it is high during the first WAKE cycle.
- `gnt_o` is combinational: `req_i & (state==ON)`. The requester drops `req_i` after the cycle in which `gnt_o` is 1.
- `req_i` during WAKE is held with no grant.
- `off_cycles_o` increments by 1 each cycle in OFF and saturates at 0xFFFFFFFF.
  - `clr_stats_i` forces it to 0.
  - If `clr_stats_i` and an increment occur in the same cycle, clear wins.
- Counter widths are `$clog2` of the parameter, minimum 1 bit.
- Reset values: state OFF, `clk_en_o`=0, `gnt_o`=0, `off_cycles_o`=0, all counters 0.
- Reset asserted mid-WAKE or mid-ON returns the block to OFF immediately, which gates the clock asynchronously. Any pending `req_i` restarts WAKE after reset release.

## Timing
- Wake-up: `req_i` rises in cycle 0 in OFF. The block is in WAKE in cycles 1..WAKE_CYCLES and in ON at cycle WAKE_CYCLES+1, where `gnt_o`=1. Latency is WAKE_CYCLES+1 cycles.
- Shut-down: with the last activity in cycle t in ON, the block is in OFF in cycle t+IDLE_CYCLES+1. `clk_en_o` is 0 from that cycle on.
- Activity in the same cycle the idle counter hits its terminal value: the block stays in ON and the counter clears.
- The gate cell latches the enable while its clock is low, so `cgra_clk_o` has no glitches. The first gated edge follows `clk_en_o` by one clock edge.

## Structure
- `cgra_clk_ctrl_pkg` holds the state enum `cgra_clk_state_e` and the width constant for the statistics counter.
- One sub-module: the `cgra_clock_gate` instance, driven by `clk_i`, `clk_en_o` and `test_en_i`, with output `cgra_clk_o`.
- The FSM, the wake/idle counters and the statistics counter are in this module.

## Test plan
- Reset, then 10 idle cycles: `clk_en_o`=0, `gnt_o`=0, `state_o`=00, `off_cycles_o`=10.
- WAKE_CYCLES=2, pulse `req_i` held from cycle 0: `state_o`=01 in cycles 1-2, `gnt_o`=1 in cycle 3, `clk_en_o`=1 from cycle 1.
- IDLE_CYCLES=16, last `req_i` at cycle t: `state_o`=10 through t+16, 00 at t+17. A `busy_i` pulse at t+16 keeps ON until t+33.
- `force_on_i`=1 for 100 cycles: ON throughout, `gnt_o` only on `req_i`, `off_cycles_o` unchanged. Then `clr_stats_i` with OFF: `off_cycles_o`=0 that cycle, then counts.
- Assert `rst_ni`=0 mid-WAKE and mid-ON: `clk_en_o`=0 and `state_o`=00 immediately. On release with `req_i`=1, WAKE restarts.
- `test_en_i`=1 in OFF: `cgra_clk_o` toggles, `clk_en_o`=0, `state_o`=00. Preload `off_cycles_o` near 0xFFFFFFFF: it saturates.
